dispensador_cambio: RTL

Coin-change dispenser that serves the far end of the vending machine's `out`/`change` interface. When the vending FSM signals a completed sale with a non-zero change code, this block turns the code into timed solenoid pulses, one per coin. It tracks the hopper coin inventory and flags any change it could not pay. It sits between `maquina_expendedora` and the physical coin hopper.

---
 rtl/dispensador_pkg.sv | 19 +
 rtl/dispensador_cambio_if.sv | 31 +++
 rtl/temporizador_pulso.sv | 39 +++
 rtl/dispensador_cambio.sv | 131 +++++++++++++
 4 files changed

// File: rtl/dispensador_pkg.sv
// rtl/dispensador_pkg.sv - shared types and constants for the coin-change dispenser
// Purpose: state encoding, change-code width and inventory width helper used by
//          the dispenser top, its interface and its pulse timer.
package dispensador_pkg;

   localparam int CHANGE_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } disp_state_t;

   // Width needed to hold an inventory count from 0 up to cap inclusive.
   function automatic int calc_stock_w(input int cap);
      return $clog2(cap + 1);
   endfunction

endpackage

// File: rtl/dispensador_cambio_if.sv
// rtl/dispensador_cambio_if.sv - request/inventory/status bundle between vending machine and dispenser
// Purpose: groups the dispenser's non-clock signals.
// Ports (master = vending side, slave = dispenser):
//   req, change, coin_in, refill      master -> slave
//   eject, busy, empty, short_fault, stock  slave -> master
interface dispensador_cambio_if #(
   parameter int STOCK_W = 4
);
   import dispensador_pkg::*;

   logic                req;
   logic [CHANGE_W-1:0] change;
   logic                coin_in;
   logic                refill;
   logic                eject;
   logic                busy;
   logic                empty;
   logic                short_fault;
   logic [STOCK_W-1:0]  stock;

   modport master (
      output req, change, coin_in, refill,
      input  eject, busy, empty, short_fault, stock
   );

   modport slave (
      input  req, change, coin_in, refill,
      output eject, busy, empty, short_fault, stock
   );

endinterface

// File: rtl/temporizador_pulso.sv
// rtl/temporizador_pulso.sv - loadable down-counter timing the pulse and gap phases
// Purpose: start_i loads load_i; the counter then decrements to zero and holds.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   start_i    load the counter this edge
//   load_i     phase length minus one
//   done_o     counter has reached zero (phase ends on the next edge)
module temporizador_pulso #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [W-1:0] load_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = load_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dispensador_cambio.sv
// rtl/dispensador_cambio.sv - turns a sale's change code into timed coin-ejector pulses
// Purpose: FSM (IDLE/PULSE/GAP), pending-coin count and hopper inventory.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   bus        slave side of dispensador_cambio_if (request in, status out)
module dispensador_cambio
   import dispensador_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int COIN_CAP     = 15,
   parameter int INIT_COINS   = 8
) (
   input logic                 clk,
   input logic                 rst,
   dispensador_cambio_if.slave bus
);

   localparam int STOCK_W = calc_stock_w(COIN_CAP);
   localparam int TMR_W   = 16;

   localparam logic [STOCK_W-1:0] CAP_V    = STOCK_W'(COIN_CAP);
   localparam logic [STOCK_W-1:0] INIT_V   = STOCK_W'(INIT_COINS);
   localparam logic [TMR_W-1:0]   PULSE_LD = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0]   GAP_LD   = TMR_W'(GAP_CYCLES - 1);

   disp_state_t         state_q, state_d;
   logic [CHANGE_W-1:0] pending_q, pending_d;
   logic [STOCK_W-1:0]  stock_q, stock_d;
   logic                fault_q, fault_d;
   logic                eject_q, busy_q, empty_q;

   logic                tmr_start, tmr_done;
   logic [TMR_W-1:0]    tmr_load;
   logic                fault_set, dec;
   logic [STOCK_W-1:0]  change_ext;
   logic                short_req;

   assign change_ext = STOCK_W'(bus.change);
   assign short_req  = (change_ext > stock_q);

   temporizador_pulso #(.W(TMR_W)) u_tmr (
      .clk     (clk),
      .rst     (rst),
      .start_i (tmr_start),
      .load_i  (tmr_load),
      .done_o  (tmr_done)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      tmr_start = 1'b0;
      tmr_load  = PULSE_LD;
      fault_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req && (bus.change != '0)) begin
               // Pay what the hopper holds; the remainder is flagged, not queued.
               pending_d = short_req ? CHANGE_W'(stock_q) : bus.change;
               fault_set = short_req;
               if (pending_d != '0) begin
                  state_d   = PULSE;
                  tmr_start = 1'b1;
               end
            end
         end
         PULSE: begin
            if (tmr_done) begin
               state_d   = GAP;
               tmr_start = 1'b1;
               tmr_load  = GAP_LD;
            end
         end
         GAP: begin
            if (tmr_done) begin
               pending_d = pending_q - CHANGE_W'(1);
               if (pending_d != '0) begin
                  state_d   = PULSE;
                  tmr_start = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One coin leaves the hopper on every edge that enters PULSE.
   assign dec = (state_d == PULSE) && (state_q != PULSE);

   always_comb begin
      stock_d = stock_q;
      if (bus.refill) begin
         stock_d = CAP_V;
      end else if (dec && !bus.coin_in) begin
         stock_d = stock_q - STOCK_W'(1);
      end else if (!dec && bus.coin_in && (stock_q != CAP_V)) begin
         stock_d = stock_q + STOCK_W'(1);
      end
      fault_d = bus.refill ? 1'b0 : (fault_q | fault_set);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         stock_q   <= INIT_V;
         fault_q   <= 1'b0;
         eject_q   <= 1'b0;
         busy_q    <= 1'b0;
         empty_q   <= (INIT_COINS == 0);
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         stock_q   <= stock_d;
         fault_q   <= fault_d;
         eject_q   <= (state_d == PULSE);
         busy_q    <= (state_d != IDLE);
         empty_q   <= (stock_d == '0);
      end
   end

   assign bus.eject       = eject_q;
   assign bus.busy        = busy_q;
   assign bus.empty       = empty_q;
   assign bus.short_fault = fault_q;
   assign bus.stock       = stock_q;

endmodule
